commit_trace_unit: RTL and testbench

- In-CPU producer of the retirement trace that the bench currently reconstructs by shadowing pipeline stages.
- Captures each instruction's PC and encoding as it leaves ID, carries it alongside the EX/MEM/WB registers honouring stall and bubble rules, and emits one commit record per retired instruction.
- Records go into a small FIFO with a valid/ready handshake, so a bench or debug port can drain them at its own rate.
- Sits beside the pipeline registers and observes only; it never drives the CPU.

---
 rtl/commit_trace_unit.sv | 135 +++++++++++++
 tb/tb_commit_trace_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_unit.sv
// Retirement trace tap: follows ID->EX->MEM->WB alongside the CPU pipeline and queues
// one commit record per retired instruction into a valid/ready FIFO.
module commit_trace_unit #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     id_valid_i,
    input  logic [31:0]              id_pc_i,
    input  logic [31:0]              id_inst_i,
    input  logic                     stall_i,
    input  logic                     wb_reg_write_i,
    input  logic [4:0]               wb_rd_i,
    input  logic [31:0]              wb_wdata_i,
    output logic                     trace_valid_o,
    input  logic                     trace_ready_i,
    output logic [31:0]              trace_pc_o,
    output logic [31:0]              trace_inst_o,
    output logic [4:0]               trace_rd_o,
    output logic [31:0]              trace_wdata_o,
    output logic [31:0]              retired_o,
    output logic [CNT_W-1:0]         drop_o,
    output logic                     overflow_o,
    output logic                     halt_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);

    localparam int DATA_W = 32;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int REC_W  = 3 * DATA_W + 5;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              vld_p0, vld_p1, vld_p2;
    logic [DATA_W-1:0] pc_p0, pc_p1, pc_p2;
    logic [DATA_W-1:0] inst_p0, inst_p1, inst_p2;

    logic [REC_W-1:0]  rec_mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;

    logic              retire, full, empty, pop, push, drop;
    logic [4:0]        rec_rd;
    logic [DATA_W-1:0] rec_wdata;
    logic [REC_W-1:0]  head;

    // Stage p0 = EX, p1 = MEM, p2 = WB; only the valids are reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (start_i) begin
            vld_p0 <= id_valid_i && !stall_i;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (start_i) begin
            pc_p0   <= id_pc_i;
            inst_p0 <= id_inst_i;
            pc_p1   <= pc_p0;
            inst_p1 <= inst_p0;
            pc_p2   <= pc_p1;
            inst_p2 <= inst_p1;
        end
    end

    // WB retire: the record pairs tracked pc/inst with the live WB write port
    always_comb begin
        retire    = start_i && vld_p2 && !halt_o;
        rec_rd    = (wb_reg_write_i && (wb_rd_i != 5'd0)) ? wb_rd_i : 5'd0;
        rec_wdata = (rec_rd != 5'd0) ? wb_wdata_i : '0;
        empty     = (count == '0);
        full      = (count == CW'(DEPTH));
        pop       = !empty && trace_ready_i;
        push      = retire && (!full || pop);
        drop      = retire && full && !pop;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            rec_mem[wr_ptr] <= {pc_p2, inst_p2, rec_rd, rec_wdata};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            retired_o  <= '0;
            drop_o     <= '0;
            overflow_o <= 1'b0;
            halt_o     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (retire) begin
                retired_o <= retired_o + 32'd1;
                if (inst_p2 == '0) halt_o <= 1'b1;
            end
            if (drop) begin
                drop_o     <= sat_inc(drop_o);
                overflow_o <= 1'b1;
            end
        end
    end

    // Head data is forced to zero while empty so stale memory never shows
    always_comb begin
        head          = rec_mem[rd_ptr];
        trace_valid_o = !empty;
        fifo_count_o  = count;
        trace_pc_o    = '0;
        trace_inst_o  = '0;
        trace_rd_o    = '0;
        trace_wdata_o = '0;
        if (!empty) begin
            trace_pc_o    = head[REC_W-1 -: DATA_W];
            trace_inst_o  = head[REC_W-DATA_W-1 -: DATA_W];
            trace_rd_o    = head[DATA_W +: 5];
            trace_wdata_o = head[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_commit_trace_unit.sv
// Bench for commit_trace_unit: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against a queue-based retirement model.
module tb_commit_trace_unit;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0, start = 1'b1, idv = 1'b0, stall = 1'b0;
    logic [31:0] id_pc = '0, id_inst = 32'h13;
    logic        wbw = 1'b0, ready = 1'b0;
    logic [4:0]  wbrd = '0;
    logic [31:0] wbd = '0;

    logic             trace_valid_o;
    logic [31:0]      trace_pc_o, trace_inst_o, trace_wdata_o, retired_o;
    logic [4:0]       trace_rd_o;
    logic [CNT_W-1:0] drop_o;
    logic             overflow_o, halt_o;
    logic [CW-1:0]    fifo_count_o;

    commit_trace_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .id_valid_i(idv),
        .id_pc_i(id_pc), .id_inst_i(id_inst), .stall_i(stall),
        .wb_reg_write_i(wbw), .wb_rd_i(wbrd), .wb_wdata_i(wbd),
        .trace_valid_o(trace_valid_o), .trace_ready_i(ready),
        .trace_pc_o(trace_pc_o), .trace_inst_o(trace_inst_o),
        .trace_rd_o(trace_rd_o), .trace_wdata_o(trace_wdata_o),
        .retired_o(retired_o), .drop_o(drop_o), .overflow_o(overflow_o),
        .halt_o(halt_o), .fifo_count_o(fifo_count_o)
    );

    typedef struct packed { logic v; logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] inst; logic [4:0] rd; logic [31:0] wd; } rec_t;

    ent_t             hist[$];
    rec_t             mq[$];
    logic [31:0]      m_ret = '0;
    logic [CNT_W-1:0] m_drop = '0;
    logic             m_ovf = 1'b0, m_halt = 1'b0;
    int               n_chk = 0, n_fail = 0;
    bit               armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        rec_t h;
        bit   v;
        v = (mq.size() > 0);
        h = v ? mq[0] : '0;
        chk("valid",    32'(trace_valid_o), 32'(v));
        chk("pc",       trace_pc_o, h.pc);
        chk("inst",     trace_inst_o, h.inst);
        chk("rd",       32'(trace_rd_o), 32'(h.rd));
        chk("wdata",    trace_wdata_o, h.wd);
        chk("retired",  retired_o, m_ret);
        chk("drop",     32'(drop_o), 32'(m_drop));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
        chk("halt",     32'(halt_o), 32'(m_halt));
        chk("count",    32'(fifo_count_o), 32'(mq.size()));
    endtask

    // WB holds whatever entered EX two enabled edges before the latest one
    task automatic model_step();
        ent_t wb;
        rec_t r;
        if (rst) begin
            hist.delete(); mq.delete();
            m_ret = '0; m_drop = '0; m_ovf = 1'b0; m_halt = 1'b0;
            return;
        end
        wb = (hist.size() >= 3) ? hist[hist.size()-3] : '0;
        if (mq.size() > 0 && ready) void'(mq.pop_front());
        if (start && wb.v && !m_halt) begin
            r.pc   = wb.pc;
            r.inst = wb.inst;
            r.rd   = (wbw && wbrd != 5'd0) ? wbrd : 5'd0;
            r.wd   = (r.rd != 5'd0) ? wbd : 32'd0;
            if (mq.size() < DEPTH) mq.push_back(r);
            else begin
                if (m_drop != '1) m_drop = m_drop + 1'b1;
                m_ovf = 1'b1;
            end
            m_ret = m_ret + 1;
            if (wb.inst == 32'd0) m_halt = 1'b1;
        end
        if (start) begin
            hist.push_back(stall ? ent_t'('0) : ent_t'{idv, id_pc, id_inst});
            if (hist.size() > 3) void'(hist.pop_front());
        end
    endtask

    task automatic cycle();
        if (armed) compare();
        model_step();
        if (rst) armed = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; idv = 1'b0; stall = 1'b0; start = 1'b1; wbw = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic id(input logic v, input logic [31:0] p, input logic s, input logic [31:0] ins);
        idv = v; id_pc = p; stall = s; id_inst = ins;
        cycle();
    endtask

    initial begin
        // Reset state and four back-to-back instructions
        do_reset();
        ready = 1'b1;
        chk("rst_valid",   32'(trace_valid_o), 32'd0);
        chk("rst_count",   32'(fifo_count_o), 32'd0);
        chk("rst_retired", retired_o, 32'd0);
        chk("rst_halt",    32'(halt_o), 32'd0);
        chk("rst_pc",      trace_pc_o, 32'd0);
        for (int i = 0; i < 4; i++) id(1'b1, 32'h10008 + 32'(4*i), 1'b0, 32'h13);
        idv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", 32'(trace_valid_o), 32'd1);
            chk("t1_pc", trace_pc_o, 32'h10008 + 32'(4*i));
            cycle();
        end
        chk("t1_retired", retired_o, 32'd4);
        chk("t1_empty", 32'(trace_valid_o), 32'd0);

        // One-cycle stall while 0x10010 sits in ID
        do_reset();
        id(1'b1, 32'h10008, 1'b0, 32'h13);
        id(1'b1, 32'h1000C, 1'b0, 32'h13);
        id(1'b1, 32'h10010, 1'b1, 32'h13);
        id(1'b1, 32'h10010, 1'b0, 32'h13);
        chk("t2_pc4", trace_pc_o, 32'h10008);
        id(1'b1, 32'h10014, 1'b0, 32'h13);
        idv = 1'b0;
        chk("t2_pc5", trace_pc_o, 32'h1000C);
        cycle();
        chk("t2_gap", 32'(trace_valid_o), 32'd0);
        cycle();
        chk("t2_pc7", trace_pc_o, 32'h10010);
        cycle();
        chk("t2_pc8", trace_pc_o, 32'h10014);
        cycle();
        chk("t2_retired", retired_o, 32'd4);

        // Flushed slot between two real instructions
        do_reset();
        id(1'b1, 32'h10008, 1'b0, 32'h13);
        id(1'b0, 32'h1000C, 1'b0, 32'h13);
        id(1'b1, 32'h10020, 1'b0, 32'h13);
        idv = 1'b0;
        repeat (5) cycle();
        chk("t3_retired", retired_o, 32'd2);

        // Destination and write-data qualification
        do_reset();
        id(1'b1, 32'h10100, 1'b0, 32'h13);
        id(1'b1, 32'h10104, 1'b0, 32'h13);
        id(1'b1, 32'h10108, 1'b0, 32'h13);
        idv = 1'b0;
        wbw = 1'b1; wbrd = 5'd5; wbd = 32'hDEADBEEF;
        cycle();
        chk("t4_rd5", 32'(trace_rd_o), 32'd5);
        chk("t4_wd5", trace_wdata_o, 32'hDEADBEEF);
        wbw = 1'b1; wbrd = 5'd0; wbd = 32'h12345678;
        cycle();
        chk("t4_rd0", 32'(trace_rd_o), 32'd0);
        chk("t4_wd0", trace_wdata_o, 32'd0);
        wbw = 1'b0; wbrd = 5'd7; wbd = 32'h55;
        cycle();
        chk("t4_rdnw", 32'(trace_rd_o), 32'd0);
        chk("t4_wdnw", trace_wdata_o, 32'd0);
        wbw = 1'b0;

        // Overflow: ten retirements into an undrained FIFO
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 10; i++) id(1'b1, 32'h20000 + 32'(4*i), 1'b0, 32'h13);
        idv = 1'b0;
        repeat (4) cycle();
        chk("t5_count", 32'(fifo_count_o), 32'd8);
        chk("t5_drop",  32'(drop_o), 32'd2);
        chk("t5_ovf",   32'(overflow_o), 32'd1);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t5_pc", trace_pc_o, 32'h20000 + 32'(4*i));
            cycle();
        end
        chk("t5_drained", 32'(trace_valid_o), 32'd0);

        // Halt on all-zero encoding, then reset mid-drain
        do_reset();
        ready = 1'b0;
        id(1'b1, 32'h30000, 1'b0, 32'h13);
        id(1'b1, 32'h30004, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) id(1'b1, 32'h30008 + 32'(4*i), 1'b0, 32'h13);
        idv = 1'b0;
        repeat (5) cycle();
        chk("t6_halt",    32'(halt_o), 32'd1);
        chk("t6_retired", retired_o, 32'd2);
        chk("t6_count",   32'(fifo_count_o), 32'd2);
        ready = 1'b1;
        cycle();
        chk("t6_zpc",   trace_pc_o, 32'h30004);
        chk("t6_zinst", trace_inst_o, 32'h0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_rvalid", 32'(trace_valid_o), 32'd0);
        chk("t6_rhalt",  32'(halt_o), 32'd0);
        chk("t6_rcount", 32'(fifo_count_o), 32'd0);

        // Randomized traffic with alternating drain pressure
        for (int k = 0; k < 4000; k++) begin
            rst     = ($urandom % 300) == 0;
            start   = ($urandom % 10) != 0;
            idv     = ($urandom % 5) != 0;
            stall   = ($urandom % 7) == 0;
            id_pc   = $urandom;
            id_inst = (($urandom % 400) == 0) ? 32'd0 : $urandom;
            ready   = ((k / 200) % 2) != 0 ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            wbw     = $urandom % 2;
            wbrd    = 5'($urandom);
            wbd     = $urandom;
            cycle();
        end
        rst = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
